// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with single-cycle logic/arith/shift ops and
// iterative unsigned multiply (shift-add) and divide (restoring), STEP_BITS
// bits retired per iteration cycle. Outputs are fully registered.
module alu_multicycle #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             div_zero_o
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int ITERS = WIDTH / STEP_BITS;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic                 ready_r;
  logic                 valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     hi_r;
  logic                 div_zero_r;
  logic [CW-1:0]        count_r;
  logic                 is_div_r;
  logic [WIDTH-1:0]     opnd_a_r;
  logic [WIDTH-1:0]     opnd_b_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     quo_r;

  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH:0]       rem_wide_s;
  logic [WIDTH+1:0]     diff_s;

  // Single-cycle operations. Rotates use a right-shift amount of -shamt mod WIDTH,
  // and shamt=0 is handled separately, so no shift by WIDTH is ever formed.
  function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0] shamt;
    logic [SHW-1:0] rsh;
    logic [WIDTH-1:0] res;
    shamt = b[SHW-1:0];
    rsh   = {SHW{1'b0}} - shamt;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      OP_ROL:  res = (shamt == {SHW{1'b0}}) ? a : ((a << shamt) | (a >> rsh));
      OP_ROR:  res = (shamt == {SHW{1'b0}}) ? a : ((a >> shamt) | (a << rsh));
      default: res = b;
    endcase
    return res;
  endfunction

  // Next accumulator values after STEP_BITS multiply or divide iterations.
  always_comb begin
    prod_s     = prod_r;
    rem_s      = rem_r;
    quo_s      = quo_r;
    sum_s      = '0;
    rem_wide_s = '0;
    diff_s     = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (is_div_r) begin
        rem_wide_s = {rem_s, quo_s[WIDTH-1]};
        quo_s      = {quo_s[WIDTH-2:0], 1'b0};
        diff_s     = {1'b0, rem_wide_s} - {2'b00, opnd_b_r};
        // No borrow means the partial remainder covered the divisor.
        quo_s[0]   = ~diff_s[WIDTH+1];
        rem_s      = diff_s[WIDTH+1] ? rem_wide_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
      end else begin
        sum_s  = {1'b0, prod_s[2*WIDTH-1:WIDTH]} + (prod_s[0] ? {1'b0, opnd_a_r} : {(WIDTH+1){1'b0}});
        prod_s = {sum_s, prod_s[WIDTH-1:1]};
      end
    end
  end

  // Control FSM and all registered outputs; flush overrides accept and completion.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      result_r   <= '0;
      hi_r       <= '0;
      div_zero_r <= 1'b0;
      count_r    <= '0;
      is_div_r   <= 1'b0;
      opnd_a_r   <= '0;
      opnd_b_r   <= '0;
      prod_r     <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
    end else if (flush_i) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      div_zero_r <= 1'b0;
      count_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_i && ready_r) begin
            if ((op_i == OP_MULU) || ((op_i == OP_DIVU) && (b_i != '0))) begin
              is_div_r <= (op_i == OP_DIVU);
              opnd_a_r <= a_i;
              opnd_b_r <= b_i;
              prod_r   <= {{WIDTH{1'b0}}, b_i};
              rem_r    <= '0;
              quo_r    <= a_i;
              count_r  <= ITERS_C;
              ready_r  <= 1'b0;
              state_r  <= ST_CALC;
            end else if (op_i == OP_DIVU) begin
              result_r   <= '1;
              hi_r       <= a_i;
              div_zero_r <= 1'b1;
              valid_r    <= 1'b1;
              ready_r    <= 1'b0;
              state_r    <= ST_DONE;
            end else begin
              result_r   <= alu_simple(op_i, a_i, b_i);
              hi_r       <= '0;
              div_zero_r <= 1'b0;
              valid_r    <= 1'b1;
              ready_r    <= 1'b0;
              state_r    <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          prod_r  <= prod_s;
          rem_r   <= rem_s;
          quo_r   <= quo_s;
          count_r <= count_r - ONE_C;
          if (count_r == ONE_C) begin
            result_r   <= is_div_r ? quo_s : prod_s[WIDTH-1:0];
            hi_r       <= is_div_r ? rem_s : prod_s[2*WIDTH-1:WIDTH];
            div_zero_r <= 1'b0;
            valid_r    <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          count_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o    = ready_r;
  assign valid_o    = valid_r;
  assign result_o   = result_r;
  assign hi_o       = hi_r;
  assign div_zero_o = div_zero_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed corner cases plus randomized ops checked against
// a plain-arithmetic reference model (WIDTH=32, STEP_BITS=1).
module tb_alu_multicycle;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    op_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  result_o;
  logic [W-1:0]  hi_o;
  logic          div_zero_o;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.WIDTH(W), .STEP_BITS(1)) dut (
    .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .hi_o(hi_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [31:0] h, output logic dz);
    logic [63:0] p;
    int s;
    s  = int'(b[4:0]);
    r  = 32'd0;
    h  = 32'd0;
    dz = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << s;
      4'd9:  r = a >> s;
      4'd10: r = $unsigned($signed(a) >>> s);
      4'd11: begin p = {a, a} << s; r = p[63:32]; end
      4'd12: begin p = {a, a} >> s; r = p[31:0]; end
      4'd13: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; h = p[63:32]; end
      4'd14: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; h = a; dz = 1'b1; end
        else begin r = a / b; h = a % b; end
      end
      default: r = b;
    endcase
  endtask

  // Issue one op, measure latency, check outputs, optionally stall the
  // consumer for 'hold' cycles (with an ignored valid_i pulse), then consume.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit pulse);
    logic [31:0] er, eh;
    logic edz;
    int lat, lat_exp, n;
    ref_model(op, a, b, er, eh, edz);
    lat_exp = ((op == 4'd13) || ((op == 4'd14) && (b != 32'd0))) ? 33 : 1;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin @(negedge clk); n++; end
    check_eq("ready_before_op", 64'(ready_o), 64'd1);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    check_eq("latency", 64'(lat), 64'(lat_exp));
    check_eq("result", 64'(result_o), 64'(er));
    check_eq("hi", 64'(hi_o), 64'(eh));
    check_eq("div_zero", 64'(div_zero_o), 64'(edz));
    for (int k = 0; k < hold; k++) begin
      if (pulse && k == 1) begin valid_i = 1'b1; op_i = 4'd1; a_i = 32'd9; b_i = 32'd3; end
      @(posedge clk); #1;
      valid_i = 1'b0;
      check_eq("hold_valid", 64'(valid_o), 64'd1);
      check_eq("hold_ready", 64'(ready_o), 64'd0);
      check_eq("hold_result", 64'(result_o), 64'(er));
      check_eq("hold_hi", 64'(hi_o), 64'(eh));
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check_eq("valid_after_consume", 64'(valid_o), 64'd0);
    check_eq("ready_after_consume", 64'(ready_o), 64'd1);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    bit seen_valid;
    n_reset = 1'b0; valid_i = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0;
    flush_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_result", 64'(result_o), 64'd0);
    check_eq("rst_hi", 64'(hi_o), 64'd0);
    check_eq("rst_dz", 64'(div_zero_o), 64'd0);
    @(negedge clk); n_reset = 1'b1;

    // Directed corner cases
    run_op(4'd0,  32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(4'd6,  32'h8000_0000, 32'd0, 0, 1'b0);
    run_op(4'd11, 32'h8000_0001, 32'd0, 0, 1'b0);
    run_op(4'd11, 32'h8000_0001, 32'd1, 0, 1'b0);
    run_op(4'd12, 32'h0000_000F, 32'd4, 0, 1'b0);
    run_op(4'd12, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op(4'd10, 32'h8000_0000, 32'd31, 0, 1'b0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(4'd14, 32'd100, 32'd7, 0, 1'b0);
    run_op(4'd14, 32'd5, 32'd0, 0, 1'b0);
    run_op(4'd14, 32'd3, 32'd10, 0, 1'b0);
    run_op(4'd15, 32'hAAAA_5555, 32'h1357_9BDF, 0, 1'b0);

    // Backpressure with an ignored valid_i pulse, then make sure nothing was queued
    run_op(4'd0, 32'd20, 32'd22, 5, 1'b1);
    seen_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (valid_o) seen_valid = 1'b1; end
    check_eq("pulse_dropped", 64'(seen_valid), 64'd0);

    // Flush during MULU CALC cycle 10
    @(negedge clk); valid_i = 1'b1; op_i = 4'd13; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    check_eq("flush_ready", 64'(ready_o), 64'd1);
    check_eq("flush_valid", 64'(valid_o), 64'd0);
    seen_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) seen_valid = 1'b1; end
    check_eq("flush_no_result", 64'(seen_valid), 64'd0);
    run_op(4'd0, 32'd1000, 32'd234, 0, 1'b0);

    // Asynchronous reset during MULU CALC cycle 10
    @(negedge clk); valid_i = 1'b1; op_i = 4'd13; a_i = 32'd12345; b_i = 32'd678;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); n_reset = 1'b0;
    #1;
    check_eq("midrst_ready", 64'(ready_o), 64'd1);
    check_eq("midrst_valid", 64'(valid_o), 64'd0);
    @(negedge clk); n_reset = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) seen_valid = 1'b1; end
    check_eq("midrst_no_result", 64'(seen_valid), 64'd0);
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(0, 40));
        2:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
